// File: rtl/des_key_schedule.sv
// DES key schedule: one PC-2 subkey per accepted round, forward or reverse order.
// Define DES_KEY_DECRYPT_EN to honour the decrypt input (reverse order via right rotations).
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        decrypt,
    input  logic        ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q;
    logic [27:0] c_q, d_q;
    logic [3:0]  round_q;
    logic        mode_q;

    logic [55:0] pc1_w;
    logic [27:0] c_load, d_load, c_step, d_step;
    logic [3:0]  round_nxt;
    logic        dec_sel;
    logic        unused_bits;

    // DES bit n (1-based, MSB first) of a W-bit vector sits at index W-n.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++)
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int unsigned i = 0; i < 48; i++)
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
        return r;
    endfunction

    function automatic logic [1:0] enc_amt(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd8, 4'd15: return 2'd1;
            default:                 return 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic [1:0] amt);
        case (amt)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

`ifdef DES_KEY_DECRYPT_EN
    function automatic logic [1:0] dec_amt(input logic [3:0] idx);
        case (idx)
            4'd0:                    return 2'd0;
            4'd1, 4'd8, 4'd15:       return 2'd1;
            default:                 return 2'd2;
        endcase
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic [1:0] amt);
        case (amt)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction
`endif

    assign pc1_w     = pc1(key_in);
    assign round_nxt = round_q + 4'd1;

`ifdef DES_KEY_DECRYPT_EN
    assign dec_sel = decrypt;

    always_comb begin
        c_load = pc1_w[55:28];
        d_load = pc1_w[27:0];
        c_step = c_q;
        d_step = d_q;
        if (!dec_sel) begin
            c_load = rotl(pc1_w[55:28], enc_amt(4'd0));
            d_load = rotl(pc1_w[27:0], enc_amt(4'd0));
        end
        if (mode_q) begin
            c_step = rotr(c_q, dec_amt(round_nxt));
            d_step = rotr(d_q, dec_amt(round_nxt));
        end else begin
            c_step = rotl(c_q, enc_amt(round_nxt));
            d_step = rotl(d_q, enc_amt(round_nxt));
        end
    end

    assign unused_bits = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8], key_in[0]};
`else
    assign dec_sel = 1'b0;

    always_comb begin
        c_load = rotl(pc1_w[55:28], enc_amt(4'd0));
        d_load = rotl(pc1_w[27:0], enc_amt(4'd0));
        c_step = rotl(c_q, enc_amt(round_nxt));
        d_step = rotl(d_q, enc_amt(round_nxt));
    end

    assign unused_bits = ^{decrypt, mode_q,
                           key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8], key_in[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        c_q     <= c_load;
                        d_q     <= d_load;
                        round_q <= '0;
                        mode_q  <= dec_sel;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    if (ready) begin
                        // Last subkey consumed: no rotation, C/D are never read again.
                        if (round_q == 4'd15) begin
                            state_q <= DONE;
                        end else begin
                            round_q <= round_nxt;
                            c_q     <= c_step;
                            d_q     <= d_step;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign subkey_valid = (state_q == ROUND);
    assign subkey       = subkey_valid ? pc2({c_q, d_q}) : '0;
    assign round_idx    = round_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule; expected subkeys come from a cumulative-shift DES reference.
module tb_des_key_schedule;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PAR = 64'h0101010101010101;

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int unsigned SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic        clk = 1'b0;
    logic        rst, start, decrypt, ready;
    logic [63:0] key_in;
    logic [47:0] subkey;
    logic        subkey_valid, busy, done;
    logic [3:0]  round_idx;

    int unsigned total = 0, bad = 0;
    int unsigned cyc = 0, nstall = 0, launch_cyc = 0;
    logic [51:0] sb [$];
    int unsigned vstart [$];
    int unsigned dcyc [$];
    logic        prev_valid = 1'b0;
    logic        mon_en = 1'b0;

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_in       (key_in),
        .decrypt      (decrypt),
        .ready        (ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Subkey for DES round n (1..16): rotate C0/D0 left by the running shift total.
    function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int unsigned n);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] r;
        int unsigned tot = 0;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1[i]];
            d[27-i] = k[64-PC1[i+28]];
        end
        for (int j = 0; j < int'(n); j++) tot += SH[j];
        for (int j = 0; j < int'(tot); j++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    task automatic push_sched(input logic [63:0] k, input logic d, input bit known);
        logic        eff;
        int unsigned n;
        logic [47:0] ks;
`ifdef DES_KEY_DECRYPT_EN
        eff = d;
`else
        eff = 1'b0 & d;
`endif
        for (int i = 0; i < 16; i++) begin
            n  = eff ? 16 - i : i + 1;
            ks = ref_subkey(k, n);
            if (known && n == 1)  ks = 48'h1B02EFFC7072;
            if (known && n == 16) ks = 48'hCB3D8B0E17F5;
            sb.push_back({4'(i), ks});
        end
    endtask

    task automatic launch(input logic [63:0] k, input logic d);
        @(posedge clk); #1;
        key_in = k; decrypt = d; start = 1'b1;
        @(posedge clk); #1;
        launch_cyc = cyc;
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = ~d;
    endtask

    task automatic run_until_done(input bit rnd, input string tag, input int unsigned lat);
        int unsigned n0 = dcyc.size();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk); #1;
            if (dcyc.size() > n0) begin ok = 1'b1; break; end
        end
        check({tag, "_done"}, 64'(ok), 1);
        ready = 1'b1;
        if (ok) begin
            check({tag, "_first"}, 64'(vstart[$]), 64'(launch_cyc));
            if (lat != 0) check({tag, "_lat"}, 64'(dcyc[$] - vstart[$]), 64'(lat));
        end
        check({tag, "_drain"}, 64'(sb.size()), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(subkey_valid), 0);
        check({tag, "_busy"},  64'(busy), 0);
        check({tag, "_done"},  64'(done), 0);
        check({tag, "_subkey"}, 64'(subkey), 0);
        check({tag, "_idx"},   64'(round_idx), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (subkey_valid) begin
                    if (!prev_valid) vstart.push_back(cyc);
                    if (sb.size() == 0) begin
                        check("sk_unexpected", 1, 0);
                    end else begin
                        check(ready ? "sk" : "sk_stall", {12'b0, round_idx, subkey}, {12'b0, sb[0]});
                        if (ready) void'(sb.pop_front());
                        else nstall++;
                    end
                end else begin
                    check("idle_subkey", 64'(subkey), 0);
                    if (!done) check("idle_busy", 64'(busy), 0);
                end
                if (done) begin
                    dcyc.push_back(cyc);
                    check("done_busy", 64'(busy), 1);
                    check("done_valid", 64'(subkey_valid), 0);
                end
                prev_valid = subkey_valid;
            end
        end
    end

    initial begin
        int unsigned nv, nd;
        logic [63:0] k;
        logic        d;
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; ready = 1'b0; key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        rst = 1'b0; ready = 1'b1; mon_en = 1'b1;

        push_sched(KEY, 1'b0, 1'b1);
        launch(KEY, 1'b0);
        run_until_done(1'b0, "enc", 16);

        push_sched(KEY, 1'b1, 1'b1);
        launch(KEY, 1'b1);
        run_until_done(1'b0, "dec", 16);

        nstall = 0;
        push_sched(KEY, 1'b0, 1'b1);
        launch(KEY, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (round_idx == 4'd3) break;
            @(posedge clk); #1;
        end
        check("stall_at3", 64'(round_idx), 3);
        ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        ready = 1'b1;
        run_until_done(1'b0, "stall", 21);
        check("stall_cnt", 64'(nstall), 5);

        push_sched(KEY, 1'b0, 1'b1);
        launch(KEY, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (round_idx == 4'd7) break;
            @(posedge clk); #1;
        end
        check("abort_at7", 64'(round_idx), 7);
        nd  = dcyc.size();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        check_zero("abort");
        repeat (20) @(negedge clk);
        #1;
        check("abort_nodone", 64'(dcyc.size()), 64'(nd));
        push_sched(KEY, 1'b0, 1'b1);
        launch(KEY, 1'b0);
        run_until_done(1'b0, "restart", 16);

        push_sched(KEY, 1'b0, 1'b1);
        launch(KEY ^ PAR, 1'b0);
        run_until_done(1'b0, "parity", 16);

        for (int t = 0; t < 3; t++) begin
            k = {$urandom, $urandom};
            d = 1'($urandom_range(0, 1));
            push_sched(k, d, 1'b0);
            launch(k, d);
            run_until_done(1'b1, "rand", 0);
        end

        push_sched(KEY, 1'b0, 1'b1);
        push_sched(KEY, 1'b0, 1'b1);
        push_sched(KEY, 1'b0, 1'b1);
        nv = vstart.size();
        nd = dcyc.size();
        @(posedge clk); #1;
        key_in = KEY; decrypt = 1'b0; ready = 1'b1; start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (vstart.size() >= nv + 3) break;
        end
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dcyc.size() >= nd + 3) break;
            @(negedge clk); #1;
        end
        check("held_starts", 64'(vstart.size()), 64'(nv + 3));
        check("held_dones", 64'(dcyc.size()), 64'(nd + 3));
        if (vstart.size() >= nv + 3 && dcyc.size() >= nd + 3) begin
            check("held_gap1", 64'(vstart[nv+1] - vstart[nv]), 18);
            check("held_gap2", 64'(vstart[nv+2] - vstart[nv+1]), 18);
            check("held_done1", 64'(dcyc[nd] - vstart[nv]), 16);
            check("held_done2", 64'(dcyc[nd+1] - vstart[nv]), 34);
        end
        check("held_drain", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
